multi_hash_checker: RTL

MULTI_HASH_CHECKER -- requirements
Module: multi_hash_checker

---
 rtl/multi_hash_checker.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_hash_checker.sv
// multi_hash_checker: per-channel rolling digest monitor for AXI data streams; optional SEC_HALT_EN macro drives sec_halt.
// Latency: pass/fail flag on the second edge after the final beat; register acks one cycle after the request.
// Backpressure: passive observer, never drives valid/ready; register port always accepts.
module multi_hash_checker #(
    parameter int N_CH           = 3,
    parameter int DATA_WIDTH     = 128,
    parameter int HASH_BITS      = 32,
    parameter int CNT_BITS       = 16,
    parameter int REG_ADDR_WIDTH = 40,
    parameter int REG_DATA_WIDTH = 32,
    parameter logic [HASH_BITS-1:0] HASH_SEED = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            mon_valid,
    input  logic [N_CH-1:0]            mon_ready,
    input  logic [N_CH*DATA_WIDTH-1:0] mon_data,
    input  logic [N_CH-1:0]            mon_last,
    input  logic [REG_ADDR_WIDTH-1:0]  reg_wr_addr,
    input  logic [REG_DATA_WIDTH-1:0]  reg_wr_data,
    input  logic                       reg_wr_en,
    output logic                       reg_wr_ack,
    input  logic [REG_ADDR_WIDTH-1:0]  reg_rd_addr,
    input  logic                       reg_rd_en,
    output logic [REG_DATA_WIDTH-1:0]  reg_rd_data,
    output logic                       reg_rd_ack,
    output logic [N_CH-1:0]            hash_verified,
    output logic [N_CH-1:0]            hash_error,
    output logic                       irq,
    output logic [N_CH-1:0]            sec_halt
);
    localparam int N_SLICE = DATA_WIDTH / HASH_BITS;
    localparam int CHW     = REG_ADDR_WIDTH - 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HASH  = 3'd1,
        S_CHECK = 3'd2,
        S_PASS  = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t              st        [N_CH];
    state_t              st_n      [N_CH];
    logic [HASH_BITS-1:0] h        [N_CH];
    logic [HASH_BITS-1:0] h_n      [N_CH];
    logic [HASH_BITS-1:0] exp_hash [N_CH];
    logic [CNT_BITS-1:0]  cnt      [N_CH];
    logic [CNT_BITS-1:0]  cnt_n    [N_CH];
    logic [CNT_BITS-1:0]  exp_beats[N_CH];
    logic [CNT_BITS-1:0]  cnt_inc;
    logic [N_CH-1:0] len_err, len_n, ver, ver_n, err, err_n;
    logic [N_CH-1:0] arm, clr, hash_wr, beats_wr, beat;
    logic [CHW-1:0]  wr_ch, rd_ch;
    logic [REG_DATA_WIDTH-1:0] rd_nxt;

    assign wr_ch = reg_wr_addr[REG_ADDR_WIDTH-1:4];
    assign rd_ch = reg_rd_addr[REG_ADDR_WIDTH-1:4];
    assign beat  = mon_valid & mon_ready;

    function automatic logic [HASH_BITS-1:0] digest_step(input logic [HASH_BITS-1:0] cur,
                                                         input logic [DATA_WIDTH-1:0] d);
        logic [HASH_BITS-1:0] f;
        f = '0;
        for (int i = 0; i < N_SLICE; i++) f ^= d[i*HASH_BITS +: HASH_BITS];
        return {cur[HASH_BITS-6:0], cur[HASH_BITS-1:HASH_BITS-5]} ^ f;
    endfunction

    function automatic logic [31:0] status_word(input logic v, input logic e, input logic l,
                                                input state_t s, input logic [CNT_BITS-1:0] n);
        return {16'(n), 9'b0, s, 1'b0, l, e, v};
    endfunction

    always_comb begin
        arm      = '0;
        clr      = '0;
        hash_wr  = '0;
        beats_wr = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (reg_wr_en && wr_ch == CHW'(c) && reg_wr_addr[1:0] == 2'b00) begin
                case (reg_wr_addr[3:2])
                    2'd0: hash_wr[c]  = 1'b1;
                    2'd1: beats_wr[c] = 1'b1;
                    2'd2: begin
                        arm[c] = reg_wr_data[0];
                        clr[c] = reg_wr_data[1];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_nxt = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_ch == CHW'(c) && reg_rd_addr[1:0] == 2'b00) begin
                case (reg_rd_addr[3:2])
                    2'd0:    rd_nxt = REG_DATA_WIDTH'(exp_hash[c]);
                    2'd1:    rd_nxt = REG_DATA_WIDTH'(exp_beats[c]);
                    2'd3:    rd_nxt = REG_DATA_WIDTH'(status_word(ver[c], err[c], len_err[c], st[c], cnt[c]));
                    default: rd_nxt = '0;
                endcase
            end
        end
    end

    always_comb begin
        cnt_inc = '0;
        len_n   = len_err;
        ver_n   = ver;
        err_n   = err;
        for (int c = 0; c < N_CH; c++) begin
            st_n[c]  = st[c];
            h_n[c]   = h[c];
            cnt_n[c] = cnt[c];
            cnt_inc  = (cnt[c] == '1) ? cnt[c] : cnt[c] + 1'b1;
            if (clr[c]) begin
                st_n[c]  = S_IDLE;
                cnt_n[c] = '0;
                len_n[c] = 1'b0;
                ver_n[c] = 1'b0;
                err_n[c] = 1'b0;
            end else begin
                case (st[c])
                    S_IDLE: if (arm[c]) begin
                        h_n[c]   = HASH_SEED;
                        cnt_n[c] = '0;
                        st_n[c]  = (exp_beats[c] == '0) ? S_CHECK : S_HASH;
                    end
                    S_HASH: if (beat[c]) begin
                        h_n[c]   = digest_step(h[c], mon_data[c*DATA_WIDTH +: DATA_WIDTH]);
                        cnt_n[c] = cnt_inc;
                        if (cnt_inc == exp_beats[c]) begin
                            st_n[c] = S_CHECK;
                        end else if (mon_last[c]) begin
                            // stream ended short: treated as a failed check
                            st_n[c]  = S_FAIL;
                            len_n[c] = 1'b1;
                            err_n[c] = 1'b1;
                        end
                    end
                    S_CHECK: if (h[c] == exp_hash[c]) begin
                        st_n[c]  = S_PASS;
                        ver_n[c] = 1'b1;
                    end else begin
                        st_n[c]  = S_FAIL;
                        err_n[c] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                st[c]        <= S_IDLE;
                h[c]         <= HASH_SEED;
                cnt[c]       <= '0;
                exp_hash[c]  <= '0;
                exp_beats[c] <= '0;
            end
            len_err     <= '0;
            ver         <= '0;
            err         <= '0;
            reg_wr_ack  <= 1'b0;
            reg_rd_ack  <= 1'b0;
            reg_rd_data <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                st[c]  <= st_n[c];
                h[c]   <= h_n[c];
                cnt[c] <= cnt_n[c];
                if (hash_wr[c])  exp_hash[c]  <= reg_wr_data[HASH_BITS-1:0];
                if (beats_wr[c]) exp_beats[c] <= CNT_BITS'(reg_wr_data);
            end
            len_err    <= len_n;
            ver        <= ver_n;
            err        <= err_n;
            reg_wr_ack <= reg_wr_en;
            reg_rd_ack <= reg_rd_en;
            if (reg_rd_en) reg_rd_data <= rd_nxt;
        end
    end

    assign hash_verified = ver;
    assign hash_error    = err;
    assign irq           = |err;

`ifdef SEC_HALT_EN
    always_comb begin
        sec_halt = '0;
        for (int c = 0; c < N_CH; c++) sec_halt[c] = (st[c] == S_FAIL);
    end
`else
    assign sec_halt = '0;
`endif

endmodule
